mesh_local_port_adapter: RTL and testbench

//  Network interface between one match-PE request source and the local (l) port of one mesh router in the match-engine mesh.

---
 rtl/mesh_local_port_adapter_if.sv | 41 ++++
 rtl/mesh_local_port_adapter.sv | 104 ++++++++++
 tb/tb_mesh_local_port_adapter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mesh_local_port_adapter_if.sv
// rtl/mesh_local_port_adapter_if.sv - PE request/response and router local-port signal bundle
interface mesh_local_port_adapter_if #(
   parameter int X_SIZE          = 4,
   parameter int Y_SIZE          = 4,
   parameter int W               = 64,
   parameter int MAX_OUTSTANDING = 8
);
   localparam int X_LOG2 = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int Y_LOG2 = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   logic                     req_valid;
   logic [X_LOG2+Y_LOG2-1:0] req_bank;
   logic [W-1:0]             req_payload;
   logic                     req_ready;
   logic                     l_i_valid;
   logic [X_LOG2-1:0]        l_i_dst_x;
   logic [Y_LOG2-1:0]        l_i_dst_y;
   logic [W-1:0]             l_i_payload;
   logic                     l_i_ready;
   logic                     l_o_valid;
   logic [W-1:0]             l_o_payload;
   logic                     l_o_ready;
   logic                     rsp_valid;
   logic [W-1:0]             rsp_payload;
   logic                     rsp_ready;
   logic [CNT_W-1:0]         outstanding;
   logic                     err_underflow;

   modport master (
      output req_valid, req_bank, req_payload, l_i_ready, l_o_valid, l_o_payload, rsp_ready,
      input  req_ready, l_i_valid, l_i_dst_x, l_i_dst_y, l_i_payload, l_o_ready,
             rsp_valid, rsp_payload, outstanding, err_underflow
   );

   modport slave (
      input  req_valid, req_bank, req_payload, l_i_ready, l_o_valid, l_o_payload, rsp_ready,
      output req_ready, l_i_valid, l_i_dst_x, l_i_dst_y, l_i_payload, l_o_ready,
             rsp_valid, rsp_payload, outstanding, err_underflow
   );
endinterface

// File: rtl/mesh_local_port_adapter.sv
// rtl/mesh_local_port_adapter.sv - PE-to-mesh local port adapter: injection FIFO, ejection skid, outstanding throttle
module mesh_local_port_adapter #(
   parameter int X_SIZE          = 4,
   parameter int Y_SIZE          = 4,
   parameter int W               = 64,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   mesh_local_port_adapter_if.slave   bus
);
   localparam int X_LOG2 = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int Y_LOG2 = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int EW     = X_LOG2 + Y_LOG2 + W;

   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             fifo_full, fifo_empty;
   logic [EW-1:0]    head;
   logic [W-1:0]     sk0, sk1;
   logic [1:0]       sk_cnt;
   logic [CNT_W-1:0] outstanding_q;
   logic             err_q;
   logic             req_fire, inj_fire, ej_fire, rsp_fire;

   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head       = mem[rptr[AW-1:0]];

   // Readies come only from registered state; reset forces them low asynchronously.
   assign bus.req_ready = !rst && !fifo_full && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
   assign bus.l_o_ready = !rst && (sk_cnt < 2'd2);
   assign bus.l_i_valid = !fifo_empty;
   assign bus.rsp_valid = (sk_cnt != 2'd0);

   assign bus.l_i_payload = bus.l_i_valid ? head[W-1:0] : '0;
   assign bus.l_i_dst_x   = bus.l_i_valid ? head[W +: X_LOG2] : '0;
   assign bus.l_i_dst_y   = bus.l_i_valid ? head[W+X_LOG2 +: Y_LOG2] : '0;
   assign bus.rsp_payload = bus.rsp_valid ? sk0 : '0;
   assign bus.outstanding   = outstanding_q;
   assign bus.err_underflow = err_q;

   assign req_fire = bus.req_valid & bus.req_ready;
   assign inj_fire = bus.l_i_valid & bus.l_i_ready;
   assign ej_fire  = bus.l_o_valid & bus.l_o_ready;
   assign rsp_fire = bus.rsp_valid & bus.rsp_ready;

   // req_bank is {y, x}, so the entry {bank, payload} is already {dst_y, dst_x, payload}.
   always_ff @(posedge clk) begin
      if (req_fire) mem[wptr[AW-1:0]] <= {bus.req_bank, bus.req_payload};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (req_fire) wptr <= wptr + 1'b1;
         if (inj_fire) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         if (ej_fire && outstanding_q == '0) begin
            err_q <= 1'b1;
            if (req_fire) outstanding_q <= outstanding_q + CNT_W'(1);
         end else if (req_fire && !ej_fire) begin
            outstanding_q <= outstanding_q + CNT_W'(1);
         end else if (ej_fire && !req_fire) begin
            outstanding_q <= outstanding_q - CNT_W'(1);
         end
      end
   end

   // sk0 is always the oldest entry; a simultaneous push/pop at one entry replaces it in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk0    <= '0;
         sk1    <= '0;
         sk_cnt <= 2'd0;
      end else begin
         case ({ej_fire, rsp_fire})
            2'b10: begin
               if (sk_cnt == 2'd0) sk0 <= bus.l_o_payload;
               else                sk1 <= bus.l_o_payload;
               sk_cnt <= sk_cnt + 2'd1;
            end
            2'b01: begin
               sk0    <= sk1;
               sk_cnt <= sk_cnt - 2'd1;
            end
            2'b11: sk0 <= bus.l_o_payload;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mesh_local_port_adapter.sv
// tb/tb_mesh_local_port_adapter.sv - directed self-checking bench for mesh_local_port_adapter
module tb_mesh_local_port_adapter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   mesh_local_port_adapter_if #(.X_SIZE(4), .Y_SIZE(4), .W(64), .MAX_OUTSTANDING(8)) bus ();

   mesh_local_port_adapter #(
      .X_SIZE(4), .Y_SIZE(4), .W(64), .FIFO_DEPTH(4), .MAX_OUTSTANDING(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req_valid = 0; bus.req_bank = '0; bus.req_payload = '0;
      bus.l_i_ready = 0; bus.l_o_valid = 0; bus.l_o_payload = '0; bus.rsp_ready = 0;
      rst = 1;
      tick();
      n_total++; if (bus.l_i_valid !== 1'b0) $display("FAIL reset_l_i_valid got %0b want 0", bus.l_i_valid); else n_pass++;
      n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", bus.req_ready); else n_pass++;
      n_total++; if (bus.l_o_ready !== 1'b0) $display("FAIL reset_l_o_ready got %0b want 0", bus.l_o_ready); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL reset_outstanding got %0d want 0", bus.outstanding); else n_pass++;
      n_total++; if (bus.err_underflow !== 1'b0) $display("FAIL reset_err got %0b want 0", bus.err_underflow); else n_pass++;
      rst = 0;
      tick();
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_release_req_ready got %0b want 1", bus.req_ready); else n_pass++;
      n_total++; if (bus.l_o_ready !== 1'b1) $display("FAIL reset_release_l_o_ready got %0b want 1", bus.l_o_ready); else n_pass++;
   endtask

   task automatic test_single();
      bus.req_valid = 1; bus.req_bank = 4'b1001; bus.req_payload = 64'hA5; bus.l_i_ready = 0;
      n_total++; if (bus.l_i_valid !== 1'b0) $display("FAIL single_pre_valid got %0b want 0", bus.l_i_valid); else n_pass++;
      tick();
      bus.req_valid = 0;
      n_total++; if (bus.l_i_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", bus.l_i_valid); else n_pass++;
      n_total++; if (bus.l_i_dst_x !== 2'd1) $display("FAIL single_dst_x got %0d want 1", bus.l_i_dst_x); else n_pass++;
      n_total++; if (bus.l_i_dst_y !== 2'd2) $display("FAIL single_dst_y got %0d want 2", bus.l_i_dst_y); else n_pass++;
      n_total++; if (bus.l_i_payload !== 64'hA5) $display("FAIL single_payload got %0h want a5", bus.l_i_payload); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd1) $display("FAIL single_outstanding got %0d want 1", bus.outstanding); else n_pass++;
      bus.l_i_ready = 1;
      tick();
      bus.l_i_ready = 0;
      n_total++; if (bus.l_i_valid !== 1'b0) $display("FAIL single_drained got %0b want 0", bus.l_i_valid); else n_pass++;
      bus.l_o_valid = 1; bus.l_o_payload = 64'hA5;
      tick();
      bus.l_o_valid = 0;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL single_returned got %0d want 0", bus.outstanding); else n_pass++;
      n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %0b want 1", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_payload !== 64'hA5) $display("FAIL single_rsp_payload got %0h want a5", bus.rsp_payload); else n_pass++;
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_done got %0b want 0", bus.rsp_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic last_ready = 1'b1;
      bus.l_i_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         bus.req_valid = 1; bus.req_payload = 64'(i); bus.req_bank = 4'(i);
         last_ready = bus.req_ready;
         if (bus.req_ready) acc++;
         tick();
      end
      bus.req_valid = 0;
      n_total++; if (acc !== 4) $display("FAIL bp_accepted got %0d want 4", acc); else n_pass++;
      n_total++; if (last_ready !== 1'b0) $display("FAIL bp_fifth_ready got %0b want 0", last_ready); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready got %0b want 0", bus.req_ready); else n_pass++;
      tick();
      n_total++; if (bus.l_i_payload !== 64'd1) $display("FAIL bp_head_stable got %0d want 1", bus.l_i_payload); else n_pass++;
      bus.l_i_ready = 1;
      for (int k = 1; k <= 4; k++) begin
         n_total++; if (bus.l_i_valid !== 1'b1 || bus.l_i_payload !== 64'(k) || bus.l_i_dst_x !== 2'(k))
            $display("FAIL bp_drain_%0d got v=%0b p=%0d x=%0d want v=1 p=%0d x=%0d",
                     k, bus.l_i_valid, bus.l_i_payload, bus.l_i_dst_x, k, k % 4);
         else n_pass++;
         tick();
      end
      bus.l_i_ready = 0;
      n_total++; if (bus.l_i_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", bus.l_i_valid); else n_pass++;
      bus.l_o_valid = 1; bus.rsp_ready = 1;
      repeat (4) tick();
      bus.l_o_valid = 0;
      tick();
      bus.rsp_ready = 0;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL bp_cleared got %0d want 0", bus.outstanding); else n_pass++;
   endtask

   task automatic test_limit();
      int acc = 0;
      bus.l_i_ready = 1; bus.rsp_ready = 1;
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = 1; bus.req_payload = 64'(100 + i); bus.req_bank = 4'(i);
         if (bus.req_ready) acc++;
         tick();
      end
      bus.req_valid = 0;
      n_total++; if (acc !== 8) $display("FAIL limit_accepted got %0d want 8", acc); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd8) $display("FAIL limit_outstanding got %0d want 8", bus.outstanding); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL limit_req_ready got %0b want 0", bus.req_ready); else n_pass++;
      tick();
      bus.l_o_valid = 1;
      tick();
      bus.l_o_valid = 0;
      n_total++; if (bus.outstanding !== 4'd7) $display("FAIL limit_after_rsp got %0d want 7", bus.outstanding); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL limit_reopen got %0b want 1", bus.req_ready); else n_pass++;
      bus.l_o_valid = 1;
      repeat (7) tick();
      bus.l_o_valid = 0;
      tick();
      bus.rsp_ready = 0; bus.l_i_ready = 0;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL limit_cleared got %0d want 0", bus.outstanding); else n_pass++;
   endtask

   task automatic test_ejection();
      int acc = 0;
      bus.l_i_ready = 1; bus.req_valid = 1;
      repeat (3) tick();
      bus.req_valid = 0;
      tick();
      bus.l_i_ready = 0;
      n_total++; if (bus.outstanding !== 4'd3) $display("FAIL ej_setup got %0d want 3", bus.outstanding); else n_pass++;
      bus.rsp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus.l_o_valid = 1; bus.l_o_payload = 64'h100 + 64'(i);
         if (bus.l_o_ready) acc++;
         tick();
      end
      bus.l_o_valid = 0;
      n_total++; if (acc !== 2) $display("FAIL ej_accepted got %0d want 2", acc); else n_pass++;
      n_total++; if (bus.l_o_ready !== 1'b0) $display("FAIL ej_l_o_ready got %0b want 0", bus.l_o_ready); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd1) $display("FAIL ej_outstanding got %0d want 1", bus.outstanding); else n_pass++;
      bus.rsp_ready = 1;
      n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_payload !== 64'h100) $display("FAIL ej_rsp0 got v=%0b p=%0h want v=1 p=100", bus.rsp_valid, bus.rsp_payload); else n_pass++;
      tick();
      n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_payload !== 64'h101) $display("FAIL ej_rsp1 got v=%0b p=%0h want v=1 p=101", bus.rsp_valid, bus.rsp_payload); else n_pass++;
      tick();
      n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL ej_rsp_empty got %0b want 0", bus.rsp_valid); else n_pass++;
      bus.l_o_valid = 1; bus.l_o_payload = 64'h102;
      tick();
      bus.l_o_valid = 0;
      n_total++; if (bus.rsp_payload !== 64'h102) $display("FAIL ej_rsp2 got %0h want 102", bus.rsp_payload); else n_pass++;
      tick();
      bus.rsp_ready = 0;
      n_total++; if (bus.outstanding !== 4'd0 || bus.err_underflow !== 1'b0) $display("FAIL ej_final got o=%0d e=%0b want o=0 e=0", bus.outstanding, bus.err_underflow); else n_pass++;
   endtask

   task automatic test_underflow();
      bus.l_o_valid = 1; bus.l_o_payload = 64'hDEAD;
      tick();
      bus.l_o_valid = 0;
      n_total++; if (bus.err_underflow !== 1'b1) $display("FAIL uf_set got %0b want 1", bus.err_underflow); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL uf_count got %0d want 0", bus.outstanding); else n_pass++;
      bus.rsp_ready = 1;
      repeat (3) tick();
      bus.rsp_ready = 0;
      n_total++; if (bus.err_underflow !== 1'b1) $display("FAIL uf_sticky got %0b want 1", bus.err_underflow); else n_pass++;
      bus.l_i_ready = 1; bus.req_valid = 1;
      repeat (3) tick();
      n_total++; if (bus.outstanding !== 4'd3) $display("FAIL simul_setup got %0d want 3", bus.outstanding); else n_pass++;
      bus.l_o_valid = 1; bus.l_o_payload = 64'h77;
      tick();
      bus.l_o_valid = 0; bus.req_valid = 0;
      n_total++; if (bus.outstanding !== 4'd3) $display("FAIL simul_hold got %0d want 3", bus.outstanding); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.l_i_ready = 0; bus.req_valid = 1; bus.req_payload = 64'h55;
      tick();
      bus.req_valid = 0;
      bus.l_o_valid = 1; bus.l_o_payload = 64'h66;
      tick();
      bus.l_o_valid = 0;
      #2 rst = 1;
      #1;
      n_total++; if (bus.l_i_valid !== 1'b0 || bus.l_i_payload !== 64'd0) $display("FAIL mid_l_i got v=%0b p=%0h want v=0 p=0", bus.l_i_valid, bus.l_i_payload); else n_pass++;
      n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %0b want 0", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.outstanding !== 4'd0) $display("FAIL mid_outstanding got %0d want 0", bus.outstanding); else n_pass++;
      n_total++; if (bus.err_underflow !== 1'b0) $display("FAIL mid_err got %0b want 0", bus.err_underflow); else n_pass++;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL mid_req_ready got %0b want 0", bus.req_ready); else n_pass++;
      tick();
      rst = 0;
      tick();
      n_total++; if (bus.req_ready !== 1'b1 || bus.l_i_valid !== 1'b0) $display("FAIL mid_release got r=%0b v=%0b want r=1 v=0", bus.req_ready, bus.l_i_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_limit();
      test_ejection();
      test_underflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
